pc_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the program counter and drives instruction-memory fetches for the CPU front end. It selects the next PC from three sources: sequential +PC_INC, branch redirect, or halt hold. It runs a request/acknowledge handshake with instruction memory and hands fetched words to the decoder through a valid/ready pair. A redirect arriving while a fetch is outstanding is buffered, and the stale data is discarded.

---
 rtl/pc_fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer for the CPU front end.
// It owns the program counter, runs the req/ack handshake with instruction
// memory, and presents fetched words to the decoder over valid/ready.
// Optional feature macro: PC_TRAP_EN (misaligned redirect traps to TRAP_VEC).
module pc_fetch_ctrl #(
  parameter int unsigned       PC_W     = 10,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [PC_W-1:0]   PC_INC   = PC_W'(2),
  parameter logic [PC_W-1:0]   TRAP_VEC = PC_W'(10'h3F0)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               dec_ready,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               halt,
  output logic [PC_W-1:0]    pc_out,
  output logic               trap
);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 pend_q, pend_d;
  logic [PC_W-1:0]      pend_target_q, pend_target_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
  logic                 take_redir;
  logic [PC_W-1:0]      redir_src;
  logic [PC_W-1:0]      redir_pc;

  // A live br_taken always wins over an older buffered target.
  assign redir_src = br_taken ? br_target : pend_target_q;

  // Odd targets either trap to TRAP_VEC or get bit0 cleared.
  assign redir_pc = (TRAP_EN && redir_src[0]) ? TRAP_VEC
                                              : {redir_src[PC_W-1:1], 1'b0};

  // State and datapath registers, all loaded from the *_d values.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      req_q         <= 1'b0;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      req_q         <= req_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Next-state selection for the fetch sequencer.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) state_d = (pend_q || br_taken) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (br_taken)       state_d = S_REQ;
        else if (dec_ready) state_d = halt ? S_HALT : S_REQ;
      end
      S_HALT: begin
        if (br_taken || !halt) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of PC, redirect buffer and registered outputs.
  always_comb begin
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    take_redir    = 1'b0;
    unique case (state_q)
      // No fetch is outstanding, so a redirect can load the PC directly.
      S_IDLE: take_redir = br_taken;
      S_REQ: begin
        if (imem_ack) begin
          if (pend_q || br_taken) begin
            // Returned word belongs to the old path: drop it.
            take_redir = 1'b1;
            pend_d     = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
          end
        end else if (br_taken) begin
          // Address must stay stable until ack, so buffer the target.
          pend_d        = 1'b1;
          pend_target_d = br_target;
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          valid_d    = 1'b0;
          take_redir = 1'b1;
        end else if (dec_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_q + PC_INC;
        end
      end
      S_HALT: take_redir = br_taken;
      default: ;
    endcase
    if (take_redir) pc_d = redir_pc;
    req_d = (state_d == S_REQ);
  end

`ifdef PC_TRAP_EN
  logic trap_q;

  // One-cycle trap pulse aligned with the PC loading TRAP_VEC.
  always_ff @(posedge clk) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= take_redir && redir_src[0];
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
// Build with +define+PC_TRAP_EN to check the trap variant.
module tb_pc_fetch_ctrl;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 16;

`ifdef PC_TRAP_EN
  localparam logic [PC_W-1:0] EXP_AL   = 10'h3F0;
  localparam logic            EXP_TRAP = 1'b1;
`else
  localparam logic [PC_W-1:0] EXP_AL   = 10'h030;
  localparam logic            EXP_TRAP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               dec_ready;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               halt;
  logic [PC_W-1:0]    pc_out;
  logic               trap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory model: word content is a tag plus its own address.
  function automatic logic [INSTR_W-1:0] word_at(input logic [PC_W-1:0] a);
    return {6'h2B, a};
  endfunction

  assign imem_rdata = imem_ack ? word_at(imem_addr) : 16'hDEAD;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .dec_ready  (dec_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .halt       (halt),
    .pc_out     (pc_out),
    .trap       (trap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic branch_once(input logic [PC_W-1:0] tgt);
    br_taken  = 1'b1;
    br_target = tgt;
    step();
    br_taken  = 1'b0;
    br_target = '0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; dec_ready = 1'b0;
    br_taken = 1'b0; br_target = '0; halt = 1'b0;
    repeat (2) step();
    check("rst_req",   32'(imem_req),    32'h0);
    check("rst_addr",  32'(imem_addr),   32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", 32'(instr),       32'h0);
    check("rst_ipc",   32'(instr_pc),    32'h0);
    check("rst_pc",    32'(pc_out),      32'h0);
    check("rst_trap",  32'(trap),        32'h0);

    // Sequential fetch with immediate ack; one dead cycle after reset.
    reset = 1'b0; dec_ready = 1'b1;
    step();
    check("boot_req",  32'(imem_req),  32'h1);
    check("boot_addr", 32'(imem_addr), 32'h0);
    for (int k = 0; k < 4; k++) begin
      ack_once();
      check($sformatf("seq_valid%0d", k), 32'(instr_valid), 32'h1);
      check($sformatf("seq_ipc%0d", k),   32'(instr_pc),    32'(2 * k));
      check($sformatf("seq_instr%0d", k), 32'(instr),       32'(word_at(PC_W'(2 * k))));
      check($sformatf("seq_noreq%0d", k), 32'(imem_req),    32'h0);
      step();
      check($sformatf("seq_req%0d", k),  32'(imem_req),  32'h1);
      check($sformatf("seq_addr%0d", k), 32'(imem_addr), 32'(2 * k + 2));
    end
    dec_ready = 1'b0;

    // Redirect two cycles before ack while fetching at 8.
    branch_once(10'h040);
    check("pend_addr0",  32'(imem_addr),   32'h008);
    check("pend_req0",   32'(imem_req),    32'h1);
    step();
    check("pend_addr1",  32'(imem_addr),   32'h008);
    ack_once();
    check("pend_drop",   32'(instr_valid), 32'h0);
    check("pend_idle",   32'(imem_req),    32'h0);
    check("pend_pc",     32'(pc_out),      32'h040);
    step();
    check("pend_req",    32'(imem_req),    32'h1);
    check("pend_addr",   32'(imem_addr),   32'h040);

    // Hold at 0x10 with decoder stalled, then branch beats dec_ready.
    ack_once();
    branch_once(10'h010);
    check("hbr_req",  32'(imem_req),  32'h1);
    check("hbr_addr", 32'(imem_addr), 32'h010);
    ack_once();
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_valid%0d", k), 32'(instr_valid), 32'h1);
      check($sformatf("stall_instr%0d", k), 32'(instr),       32'(word_at(10'h010)));
      check($sformatf("stall_ipc%0d", k),   32'(instr_pc),    32'h010);
    end
    dec_ready = 1'b1;
    branch_once(10'h080);
    dec_ready = 1'b0;
    check("brprio_valid", 32'(instr_valid), 32'h0);
    check("brprio_req",   32'(imem_req),    32'h1);
    check("brprio_addr",  32'(imem_addr),   32'h080);

    // Halt while accepting the word at 0x20.
    ack_once();
    branch_once(10'h020);
    ack_once();
    check("halt_ipc", 32'(instr_pc), 32'h020);
    halt = 1'b1; dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("halt_valid", 32'(instr_valid), 32'h0);
    check("halt_req",   32'(imem_req),    32'h0);
    check("halt_pc",    32'(pc_out),      32'h022);
    repeat (2) step();
    check("halt_still", 32'(imem_req), 32'h0);
    halt = 1'b0;
    step();
    check("resume_req",  32'(imem_req),  32'h1);
    check("resume_addr", 32'(imem_addr), 32'h022);

    // Branch in the same cycle as ack: data dropped, idle cycle, refetch.
    imem_ack = 1'b1;
    branch_once(10'h100);
    imem_ack = 1'b0;
    check("brack_valid", 32'(instr_valid), 32'h0);
    check("brack_req",   32'(imem_req),    32'h0);
    check("brack_pc",    32'(pc_out),      32'h100);
    step();
    check("brack_addr",  32'(imem_addr),   32'h100);

    // Misaligned target through the immediate path.
    ack_once();
    branch_once(10'h031);
    check("al_addr", 32'(imem_addr), 32'(EXP_AL));
    check("al_trap", 32'(trap),      32'(EXP_TRAP));
    step();
    check("al_trap_off", 32'(trap), 32'h0);

    // Misaligned target through the pending-redirect path.
    branch_once(10'h031);
    check("alp_hold", 32'(imem_addr), 32'(EXP_AL));
    check("alp_notrap", 32'(trap),    32'h0);
    ack_once();
    check("alp_pc",   32'(pc_out),    32'(EXP_AL));
    check("alp_trap", 32'(trap),      32'(EXP_TRAP));
    step();
    check("alp_trap_off", 32'(trap),  32'h0);

    // PC wraps from 0x3FE to 0x000.
    ack_once();
    branch_once(10'h3FE);
    check("wrap_addr0", 32'(imem_addr), 32'h3FE);
    ack_once();
    check("wrap_ipc", 32'(instr_pc), 32'h3FE);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'h000);

    // Reset while holding a valid word.
    ack_once();
    check("mid_valid_pre", 32'(instr_valid), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_req",   32'(imem_req),    32'h0);
    check("mid_valid", 32'(instr_valid), 32'h0);
    check("mid_instr", 32'(instr),       32'h0);
    check("mid_ipc",   32'(instr_pc),    32'h0);
    check("mid_pc",    32'(pc_out),      32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
